cp0_regfile_exc: RTL and testbench

Parametrised CP0 system-control register file for the five-stage MIPS32 core. It holds Count, Compare, Status, Cause, EPC, BadVAddr, PRId and Config. On top of MTC0/MFC0 access, it adds a configurable Count prescaler, a configurable number of hardware interrupt lines, precise exception entry/ERET commit and a same-cycle write-to-read bypass. It sits beside the MEM/WB boundary: the MEM stage drives the write and exception-commit ports, EX reads via MFC0, and the control unit consumes `int_pending_o`.

---
 rtl/cp0_regfile_exc.sv | 228 ++++++++++++++++++++++
 tb/tb_cp0_regfile_exc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile_exc.sv
// ---------------------------------------------------------------------------
// cp0_regfile_exc
// CP0 system-control register file for the five-stage MIPS32 core.
// Holds Count, Compare, Status, Cause, EPC, BadVAddr, PRId and Config, with a
// Count prescaler, sampled hardware interrupt lines, precise exception entry,
// ERET commit and a same-cycle MTC0-to-MFC0 bypass on the read port.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   raddr_i/data_o    MFC0 address / combinational read data
//   we_i/waddr_i/
//   data_i            MTC0 write enable / address / data
//   int_i             level-sensitive external interrupt lines
//   exc_valid_i,
//   exc_code_i,
//   exc_pc_i,
//   exc_in_delay_i,
//   badvaddr_i        exception commit from MEM
//   eret_i            ERET commit from MEM
//   *_o               register contents, sticky timer flag, pending interrupt
// ---------------------------------------------------------------------------
module cp0_regfile_exc #(
   parameter int unsigned HW_INT_N   = 6,
   parameter int unsigned COUNT_DIV  = 1,
   parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
   parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4:0]          raddr_i,
   output logic [31:0]         data_o,
   input  logic                we_i,
   input  logic [4:0]          waddr_i,
   input  logic [31:0]         data_i,
   input  logic [HW_INT_N-1:0] int_i,
   input  logic                exc_valid_i,
   input  logic [4:0]          exc_code_i,
   input  logic [31:0]         exc_pc_i,
   input  logic                exc_in_delay_i,
   input  logic [31:0]         badvaddr_i,
   input  logic                eret_i,
   output logic [31:0]         count_o,
   output logic [31:0]         compare_o,
   output logic [31:0]         status_o,
   output logic [31:0]         cause_o,
   output logic [31:0]         epc_o,
   output logic [31:0]         badvaddr_o,
   output logic [31:0]         config_o,
   output logic [31:0]         prid_o,
   output logic                timer_int_o,
   output logic                int_pending_o
);

   localparam logic [4:0] A_BADVADDR = 5'd8;
   localparam logic [4:0] A_COUNT    = 5'd9;
   localparam logic [4:0] A_COMPARE  = 5'd11;
   localparam logic [4:0] A_STATUS   = 5'd12;
   localparam logic [4:0] A_CAUSE    = 5'd13;
   localparam logic [4:0] A_EPC      = 5'd14;
   localparam logic [4:0] A_PRID     = 5'd15;
   localparam logic [4:0] A_CONFIG   = 5'd16;

   localparam logic [31:0] STATUS_RST = 32'h1000_0000;
   // Software-writable Cause bits: IP[1:0], and bits 22/23.
   localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

   localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

   logic [31:0]   count_q, count_d;
   logic [31:0]   compare_q, compare_d;
   logic [31:0]   status_q, status_d;
   logic [31:0]   epc_q, epc_d;
   logic [31:0]   badvaddr_q, badvaddr_d;
   logic          timer_q, timer_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          bd_q, bd_d;
   logic [1:0]    c_hi_q, c_hi_d;     // Cause[23:22]
   logic [5:0]    ip_hw_q, ip_hw_d;   // Cause[15:10] as sampled from int_i
   logic [1:0]    ip_sw_q, ip_sw_d;   // Cause[9:8]
   logic [4:0]    exccode_q, exccode_d;

   logic        wr;
   logic        presc_wrap;
   logic [31:0] cause_wr_merge;

   // Exception and ERET commits both squash the MTC0 in the same cycle.
   assign wr         = we_i & ~exc_valid_i & ~eret_i;
   assign presc_wrap = (presc_q == PRESC_LAST);

   // Timer contributes to IP7 and TI directly so they track timer_int_o.
   assign cause_o = {bd_q, timer_q, 6'b0, c_hi_q, 6'b0,
                     ip_hw_q[5] | timer_q, ip_hw_q[4:0], ip_sw_q,
                     1'b0, exccode_q, 2'b0};

   assign count_o       = count_q;
   assign compare_o     = compare_q;
   assign status_o      = status_q;
   assign epc_o         = epc_q;
   assign badvaddr_o    = badvaddr_q;
   assign config_o      = CONFIG_VAL;
   assign prid_o        = PRID_VAL;
   assign timer_int_o   = timer_q;
   assign int_pending_o = status_q[0] & ~status_q[1] &
                          (|(cause_o[15:8] & status_q[15:8]));

   assign cause_wr_merge = (cause_o & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);

   always_comb begin
      ip_hw_d = '0;
      for (int unsigned k = 0; k < HW_INT_N; k++) begin
         ip_hw_d[k] = int_i[k];
      end
   end

   always_comb begin
      presc_d = presc_wrap ? '0 : presc_q + PW'(1);

      count_d = count_q;
      if (wr && waddr_i == A_COUNT) begin
         count_d = data_i;
      end else if (presc_wrap) begin
         count_d = count_q + 32'd1;
      end

      compare_d = compare_q;
      if (wr && waddr_i == A_COMPARE) begin
         compare_d = data_i;
      end

      // A Compare write acknowledges the timer even while the match holds.
      timer_d = timer_q | ((compare_q != '0) && (count_q == compare_q));
      if (wr && waddr_i == A_COMPARE) begin
         timer_d = 1'b0;
      end

      status_d = status_q;
      if (exc_valid_i) begin
         status_d[1] = 1'b1;
      end else if (eret_i) begin
         status_d[1] = 1'b0;
      end else if (wr && waddr_i == A_STATUS) begin
         status_d = data_i;
      end

      epc_d     = epc_q;
      bd_d      = bd_q;
      exccode_d = exccode_q;
      c_hi_d    = c_hi_q;
      ip_sw_d   = ip_sw_q;
      if (exc_valid_i) begin
         exccode_d = exc_code_i;
         // Nested exceptions keep the original return point.
         if (!status_q[1]) begin
            epc_d = exc_in_delay_i ? exc_pc_i - 32'd4 : exc_pc_i;
            bd_d  = exc_in_delay_i;
         end
      end else if (wr && waddr_i == A_CAUSE) begin
         c_hi_d  = data_i[23:22];
         ip_sw_d = data_i[9:8];
      end else if (wr && waddr_i == A_EPC) begin
         epc_d = data_i;
      end

      badvaddr_d = badvaddr_q;
      if (exc_valid_i && (exc_code_i == 5'd4 || exc_code_i == 5'd5)) begin
         badvaddr_d = badvaddr_i;
      end else if (wr && waddr_i == A_BADVADDR) begin
         badvaddr_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= '0;
         compare_q  <= '0;
         status_q   <= STATUS_RST;
         epc_q      <= '0;
         badvaddr_q <= '0;
         timer_q    <= 1'b0;
         presc_q    <= '0;
         bd_q       <= 1'b0;
         c_hi_q     <= '0;
         ip_hw_q    <= '0;
         ip_sw_q    <= '0;
         exccode_q  <= '0;
      end else begin
         count_q    <= count_d;
         compare_q  <= compare_d;
         status_q   <= status_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
         timer_q    <= timer_d;
         presc_q    <= presc_d;
         bd_q       <= bd_d;
         c_hi_q     <= c_hi_d;
         ip_hw_q    <= ip_hw_d;
         ip_sw_q    <= ip_sw_d;
         exccode_q  <= exccode_d;
      end
   end

   // Read port: a write that will commit this cycle is forwarded to data_o.
   always_comb begin
      data_o = '0;
      if (!rst) begin
         unique case (raddr_i)
            A_BADVADDR: data_o = badvaddr_q;
            A_COUNT:    data_o = count_q;
            A_COMPARE:  data_o = compare_q;
            A_STATUS:   data_o = status_q;
            A_CAUSE:    data_o = cause_o;
            A_EPC:      data_o = epc_q;
            A_PRID:     data_o = PRID_VAL;
            A_CONFIG:   data_o = CONFIG_VAL;
            default:    data_o = '0;
         endcase
         if (wr && waddr_i == raddr_i) begin
            unique case (raddr_i)
               A_BADVADDR, A_COUNT, A_COMPARE, A_STATUS, A_EPC: data_o = data_i;
               A_CAUSE:  data_o = cause_wr_merge;
               default:  ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cp0_regfile_exc.sv
module tb_cp0_regfile_exc;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  raddr_i;
   logic [31:0] data_o;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] data_i;
   logic [5:0]  int_i;
   logic        exc_valid_i;
   logic [4:0]  exc_code_i;
   logic [31:0] exc_pc_i;
   logic        exc_in_delay_i;
   logic [31:0] badvaddr_i;
   logic        eret_i;
   logic [31:0] count_o, compare_o, status_o, cause_o;
   logic [31:0] epc_o, badvaddr_o, config_o, prid_o;
   logic        timer_int_o, int_pending_o;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   // Prescaler/Count reference, updated from the inputs seen at each edge.
   int unsigned m_presc = 0;
   logic [31:0] m_count = '0;
   logic        seen_zero;

   always #5 clk = ~clk;

   cp0_regfile_exc #(
      .HW_INT_N  (6),
      .COUNT_DIV (4),
      .PRID_VAL  (32'h004C_0102),
      .CONFIG_VAL(32'h0000_8000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .raddr_i       (raddr_i),
      .data_o        (data_o),
      .we_i          (we_i),
      .waddr_i       (waddr_i),
      .data_i        (data_i),
      .int_i         (int_i),
      .exc_valid_i   (exc_valid_i),
      .exc_code_i    (exc_code_i),
      .exc_pc_i      (exc_pc_i),
      .exc_in_delay_i(exc_in_delay_i),
      .badvaddr_i    (badvaddr_i),
      .eret_i        (eret_i),
      .count_o       (count_o),
      .compare_o     (compare_o),
      .status_o      (status_o),
      .cause_o       (cause_o),
      .epc_o         (epc_o),
      .badvaddr_o    (badvaddr_o),
      .config_o      (config_o),
      .prid_o        (prid_o),
      .timer_int_o   (timer_int_o),
      .int_pending_o (int_pending_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_presc = 0;
         m_count = '0;
      end else begin
         if (we_i && !exc_valid_i && !eret_i && waddr_i == 5'd9) m_count = data_i;
         else if (m_presc == 3) m_count = m_count + 32'd1;
         m_presc = (m_presc == 3) ? 0 : m_presc + 1;
      end
      #1;
   endtask

   task automatic idle();
      we_i = 1'b0; waddr_i = '0; data_i = '0;
      exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0;
      exc_in_delay_i = 1'b0; badvaddr_i = '0; eret_i = 1'b0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      we_i = 1'b1; waddr_i = a; data_i = d;
      tick();
      we_i = 1'b0;
   endtask

   task automatic take_exc(input logic [31:0] pc, input logic dly,
                           input logic [4:0] code, input logic [31:0] bad);
      exc_valid_i = 1'b1; exc_pc_i = pc; exc_in_delay_i = dly;
      exc_code_i = code; badvaddr_i = bad;
      tick();
      exc_valid_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1; raddr_i = 5'd12; int_i = '0;
      idle();
      tick();
      #1 chk("rd_in_reset", data_o, 32'h0);
      rst = 1'b0;
      #1 chk("rd_status", data_o, 32'h1000_0000);
      raddr_i = 5'd15; #1 chk("rd_prid", data_o, 32'h004C_0102);
      raddr_i = 5'd16; #1 chk("rd_config", data_o, 32'h0000_8000);
      raddr_i = 5'd3;  #1 chk("rd_unmapped", data_o, 32'h0);
      chk("rst_count", count_o, 32'h0);
      chk("rst_timer", {31'b0, timer_int_o}, 32'h0);

      // Count wrap and timer match.
      mtc0(5'd9, 32'hFFFF_FFFE);
      chk("cnt_wr", count_o, m_count);
      mtc0(5'd11, 32'h1);
      chk("cmp_wr", compare_o, 32'h1);
      seen_zero = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (m_count == 32'h1) break;
         tick();
         chk("cnt_run", count_o, m_count);
         chk("timer_pre", {31'b0, timer_int_o}, 32'h0);
         if (m_count == 32'h0) seen_zero = 1'b1;
      end
      chk("cnt_wrapped", {31'b0, seen_zero}, 32'h1);
      chk("cnt_at_cmp", count_o, 32'h1);
      chk("timer_first", {31'b0, timer_int_o}, 32'h0);
      tick();
      chk("timer_set", {31'b0, timer_int_o}, 32'h1);
      chk("cause_ip7", {31'b0, cause_o[15]}, 32'h1);
      chk("cause_ti", {31'b0, cause_o[30]}, 32'h1);
      mtc0(5'd11, 32'h1);
      chk("timer_clr", {31'b0, timer_int_o}, 32'h0);

      // Exception entry, nested exception, ERET.
      take_exc(32'h100, 1'b1, 5'd4, 32'hDEAD);
      chk("epc_dly", epc_o, 32'hFC);
      chk("bd_set", {31'b0, cause_o[31]}, 32'h1);
      chk("exccode4", {27'b0, cause_o[6:2]}, 32'd4);
      chk("badva", badvaddr_o, 32'hDEAD);
      chk("exl_set", status_o, 32'h1000_0002);
      take_exc(32'h200, 1'b0, 5'd8, 32'hBEEF);
      chk("epc_nested", epc_o, 32'hFC);
      chk("bd_nested", {31'b0, cause_o[31]}, 32'h1);
      chk("exccode8", {27'b0, cause_o[6:2]}, 32'd8);
      chk("badva_keep", badvaddr_o, 32'hDEAD);
      eret_i = 1'b1; we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000_FFFF;
      tick();
      idle();
      chk("eret_exl", status_o, 32'h1000_0000);

      // Reset while timer and EXL are set, with other inputs active.
      mtc0(5'd11, 32'h40);
      mtc0(5'd9, 32'h40);
      tick();
      chk("timer_set2", {31'b0, timer_int_o}, 32'h1);
      take_exc(32'h300, 1'b0, 5'd0, 32'h0);
      chk("exl_set2", {31'b0, status_o[1]}, 32'h1);
      rst = 1'b1; we_i = 1'b1; waddr_i = 5'd9; data_i = 32'h123;
      exc_valid_i = 1'b1; exc_code_i = 5'd4; badvaddr_i = 32'h55; int_i = 6'h3F;
      raddr_i = 5'd9;
      tick();
      chk("r_count", count_o, 32'h0);
      chk("r_compare", compare_o, 32'h0);
      chk("r_status", status_o, 32'h1000_0000);
      chk("r_cause", cause_o, 32'h0);
      chk("r_epc", epc_o, 32'h0);
      chk("r_badva", badvaddr_o, 32'h0);
      chk("r_config", config_o, 32'h0000_8000);
      chk("r_prid", prid_o, 32'h004C_0102);
      chk("r_timer", {31'b0, timer_int_o}, 32'h0);
      chk("r_pend", {31'b0, int_pending_o}, 32'h0);
      chk("r_data", data_o, 32'h0);
      rst = 1'b0; int_i = '0;
      idle();

      // Interrupt sampling and pending.
      mtc0(5'd12, 32'h0000_1001);
      int_i = 6'b000100;
      #1 chk("ip_latency", {31'b0, cause_o[12]}, 32'h0);
      tick();
      chk("ip_hw2", {24'b0, cause_o[15:8]}, 32'h10);
      chk("pend_on", {31'b0, int_pending_o}, 32'h1);
      take_exc(32'h80, 1'b0, 5'd0, 32'h0);
      chk("pend_exl", {31'b0, int_pending_o}, 32'h0);

      // Same-cycle bypass and dropped write.
      rst = 1'b1; tick(); rst = 1'b0;
      int_i = 6'b000101;
      tick();
      raddr_i = 5'd13; we_i = 1'b1; waddr_i = 5'd13; data_i = 32'hFFFF_FFFF;
      #1 chk("byp_cause", data_o, 32'h00C0_1700);
      tick();
      chk("cause_wr", cause_o, 32'h00C0_1700);
      data_i = 32'h0; exc_valid_i = 1'b1; exc_pc_i = 32'h40; exc_code_i = 5'd0;
      #1 chk("byp_dropped", data_o, 32'h00C0_1700);
      tick();
      idle();
      chk("cause_drop", cause_o, 32'h00C0_1700);
      chk("epc_drop", epc_o, 32'h40);
      raddr_i = 5'd15; we_i = 1'b1; waddr_i = 5'd15; data_i = 32'h1234;
      #1 chk("byp_prid", data_o, 32'h004C_0102);
      raddr_i = 5'd9; waddr_i = 5'd9; data_i = 32'hABCD;
      #1 chk("byp_count", data_o, 32'hABCD);
      tick();
      idle();
      chk("cnt_wr2", count_o, 32'hABCD);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
